// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and its surroundings.
// master: the control unit (drives handshake ready and datapath controls).
// slave:  instruction source plus datapath (drives opcode, flags and acks).
// The `illegal` signal exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ack;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                busy;
`ifdef ILLEGAL_TRAP_EN
    logic                illegal;
`endif

    modport master (
        input  instr_valid, opcode, zero, mem_ack,
        output instr_ready, ir_we, pc_we, pc_src, reg_dst, alu_src, mem_to_reg,
               alu_op, mem_read, mem_write, reg_write, busy
`ifdef ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output instr_valid, opcode, zero, mem_ack,
        input  instr_ready, ir_we, pc_we, pc_src, reg_dst, alu_src, mem_to_reg,
               alu_op, mem_read, mem_write, reg_write, busy
`ifdef ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: accepts an opcode over valid/ready, walks
// IDLE-DECODE-EXEC-MEM-WB and issues state-qualified datapath strobes with
// exactly one PC update per retired instruction.
// Optional feature macro: ILLEGAL_TRAP_EN -- illegal opcodes park the unit in
// a TRAP state (left only by reset) and raise `illegal`; otherwise an illegal
// opcode retires as a NOP.
module multicycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_unit_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_LD  = 3'd0;
    localparam logic [2:0] C_ST  = 3'd1;
    localparam logic [2:0] C_R   = 3'd2;
    localparam logic [2:0] C_BEQ = 3'd3;
    localparam logic [2:0] C_BNE = 3'd4;
    localparam logic [2:0] C_JMP = 3'd5;
    localparam logic [2:0] C_ILL = 3'd6;

    localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_MEM = ALU_OP_W'(2'b10);

    logic [2:0]          state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [2:0]          cls_q, cls_d;
    logic                reg_dst_q, reg_dst_d;
    logic                alu_src_q, alu_src_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;

    logic       instr_ready;
    logic       accept;
    logic       ir_we, pc_we, mem_read, mem_write, reg_write;
    logic [1:0] pc_src;

    // Instruction class from the low nibble; any set upper bit is illegal.
    function automatic logic [2:0] decode_class(input logic [OPCODE_W-1:0] op);
        if ((op >> 4) != '0) return C_ILL;
        case (op[3:0]) inside
            4'd0:          return C_LD;
            4'd1:          return C_ST;
            [4'd2:4'd9]:   return C_R;
            4'd11:         return C_BEQ;
            4'd12:         return C_BNE;
            4'd13:         return C_JMP;
            default:       return C_ILL;
        endcase
    endfunction

    // rst_n gates acceptance so an undriven instr_valid cannot strobe ir_we in reset.
    assign instr_ready = (state_q == S_IDLE);
    assign accept      = bus.instr_valid && instr_ready && rst_n;

    // Next state, opcode capture and select decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d      = state_q;
        opcode_d     = opcode_q;
        cls_d        = cls_q;
        reg_dst_d    = reg_dst_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_op_d     = alu_op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opcode_d = bus.opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d        = decode_class(opcode_q);
                reg_dst_d    = 1'b0;
                alu_src_d    = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_op_d     = ALU_R;
                case (cls_d)
                    C_LD:        begin alu_src_d = 1'b1; mem_to_reg_d = 1'b1; alu_op_d = ALU_MEM; end
                    C_ST:        begin alu_src_d = 1'b1; alu_op_d = ALU_MEM; end
                    C_R:         begin reg_dst_d = 1'b1; alu_op_d = ALU_R; end
                    C_BEQ, C_BNE: alu_op_d = ALU_BR;
                    default:     ;
                endcase
`ifdef ILLEGAL_TRAP_EN
                state_d = (cls_d == C_ILL) ? S_TRAP : S_EXEC;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                case (cls_q)
                    C_R:        state_d = S_WB;
                    C_LD, C_ST: state_d = S_MEM;
                    default:    state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ack) state_d = (cls_q == C_LD) ? S_WB : S_IDLE;
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // State-qualified strobes; only the current state can raise any of them.
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        case (state_q)
            S_IDLE: ir_we = accept;
            S_EXEC: begin
                case (cls_q)
                    C_BEQ: begin pc_we = 1'b1; pc_src = bus.zero  ? 2'b01 : 2'b00; end
                    C_BNE: begin pc_we = 1'b1; pc_src = !bus.zero ? 2'b01 : 2'b00; end
                    C_JMP: begin pc_we = 1'b1; pc_src = 2'b10; end
                    C_ILL: pc_we = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LD);
                mem_write = (cls_q == C_ST);
                pc_we     = (cls_q == C_ST) && bus.mem_ack;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // State, latched opcode and held datapath selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            cls_q        <= C_ILL;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            cls_q        <= cls_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.busy        = ~instr_ready;
    assign bus.ir_we       = ir_we;
    assign bus.pc_we       = pc_we;
    assign bus.pc_src      = pc_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.reg_dst     = reg_dst_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.mem_to_reg  = mem_to_reg_q;
    assign bus.alu_op      = alu_op_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal     = (state_q == S_TRAP);
`endif
endmodule
